// File: rtl/endmember_store.sv
// Endmember spectrum buffer: appends one band per cycle, commits full vectors as new columns,
// and serves two 1-cycle-latency read ports. Optional range checking: ENDMEMBER_STORE_RANGE_CHECK_EN.
module endmember_store #(
  parameter int I_WIDTH          = 16,
  parameter int SPECTRAL_BANDS   = 103,
  parameter int TOTAL_ENDMEMBERS = 20,
  localparam int COL_W = $clog2(TOTAL_ENDMEMBERS),
  localparam int ROW_W = $clog2(SPECTRAL_BANDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [I_WIDTH-1:0] wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic               commit,
  input  logic [COL_W-1:0]   U_col,
  input  logic [ROW_W-1:0]   U_row,
  input  logic [COL_W-1:0]   new_vectorT_row,
  input  logic [ROW_W-1:0]   new_vectorT_col,
  input  logic               addr_valid_in,
  output logic [I_WIDTH-1:0] U_in,
  output logic [I_WIDTH-1:0] new_vectorT_in,
  output logic               valid_out,
  output logic [COL_W-1:0]   size,
  output logic               empty,
  output logic               full,
  output logic               addr_err
);

  localparam int DEPTH   = TOTAL_ENDMEMBERS * SPECTRAL_BANDS;
  localparam int CNT_W   = $clog2(TOTAL_ENDMEMBERS + 1);
  // Read addresses are formed from full-range port values, so they may exceed DEPTH.
  localparam int RADDR_W = $clog2((2 ** COL_W) * SPECTRAL_BANDS + (2 ** ROW_W));

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [ROW_W-1:0]   wr_row;
  logic               accept;
  logic               wr_en;
  logic               last_band;
  logic [RADDR_W-1:0] wr_addr;
  logic [RADDR_W-1:0] addr_a;
  logic [RADDR_W-1:0] addr_b;
  logic               bad_a;
  logic               bad_b;

  logic [I_WIDTH-1:0] mem [0:DEPTH-1];

  function automatic logic [RADDR_W-1:0] word_addr(input logic [COL_W-1:0] col,
                                                    input logic [ROW_W-1:0] row);
    return RADDR_W'(col) * RADDR_W'(SPECTRAL_BANDS) + RADDR_W'(row);
  endfunction

  assign wr_ready  = (state != FULL);
  assign accept    = wr_valid & wr_ready;
  assign wr_en     = accept & ~clear;
  assign last_band = (wr_row == ROW_W'(SPECTRAL_BANDS - 1));
  assign wr_addr   = word_addr(COL_W'(count), wr_row);
  assign addr_a    = word_addr(U_col, U_row);
  assign addr_b    = word_addr(new_vectorT_row, new_vectorT_col);

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(TOTAL_ENDMEMBERS));
  assign size  = empty ? '0 : COL_W'(count - 1'b1);

  // Append FSM: IDLE and LOAD share the per-sample behaviour; wr_row is 0 in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      wr_row <= '0;
      commit <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      commit <= 1'b0;
      if (clear) begin
        state  <= IDLE;
        count  <= '0;
        wr_row <= '0;
      end else begin
        case (state)
          IDLE, LOAD: begin
            if (accept) begin
              if (last_band) begin
                wr_row <= '0;
                count  <= count + 1'b1;
                commit <= 1'b1;
                state  <= (count == CNT_W'(TOTAL_ENDMEMBERS - 1)) ? FULL : IDLE;
              end else begin
                wr_row <= wr_row + 1'b1;
                state  <= LOAD;
              end
            end
          end
          FULL:    state <= FULL;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; contents persist across clear and rst.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

`ifdef ENDMEMBER_STORE_RANGE_CHECK_EN
  assign bad_a = empty | (U_col > size) | (int'(U_row) >= SPECTRAL_BANDS);
  assign bad_b = empty | (new_vectorT_row > size) | (int'(new_vectorT_col) >= SPECTRAL_BANDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                addr_err <= 1'b0;
    else if (clear)                         addr_err <= 1'b0;
    else if (addr_valid_in & (bad_a | bad_b)) addr_err <= 1'b1;
  end
`else
  assign bad_a    = 1'b0;
  assign bad_b    = 1'b0;
  assign addr_err = 1'b0;
`endif

  // Read ports: registered data, valid_out is addr_valid_in delayed one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      U_in           <= '0;
      new_vectorT_in <= '0;
      valid_out      <= 1'b0;
    end else begin
      valid_out <= addr_valid_in;
      if (addr_valid_in) begin
        U_in           <= bad_a ? '0 : mem[addr_a];
        new_vectorT_in <= bad_b ? '0 : mem[addr_b];
      end
    end
  end

endmodule

// File: tb/tb_endmember_store.sv
// Self-checking bench for endmember_store: directed sequence with random gaps and random reads,
// checked against an array model of committed columns. Range tests run with ENDMEMBER_STORE_RANGE_CHECK_EN.
module tb_endmember_store;

  localparam int W  = 16;
  localparam int NB = 103;
  localparam int NE = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [W-1:0]  wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          commit;
  logic [4:0]    U_col;
  logic [6:0]    U_row;
  logic [4:0]    nvt_row;
  logic [6:0]    nvt_col;
  logic          addr_valid_in;
  logic [W-1:0]  U_in;
  logic [W-1:0]  nvt_in;
  logic          valid_out;
  logic [4:0]    size;
  logic          empty;
  logic          full;
  logic          addr_err;

  int n_checks = 0;
  int n_errors = 0;
  int model_mem [NE*NB];
  int cnt = 0;
  int vcount;

  endmember_store dut (
    .clk(clk), .rst(rst), .clear(clear), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .commit(commit), .U_col(U_col), .U_row(U_row),
    .new_vectorT_row(nvt_row), .new_vectorT_col(nvt_col), .addr_valid_in(addr_valid_in),
    .U_in(U_in), .new_vectorT_in(nvt_in), .valid_out(valid_out), .size(size),
    .empty(empty), .full(full), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected word: committed columns come from the model, anything else reads as 0.
  function automatic int exp_word(input int col, input int row);
    if (col < cnt && row < NB) return model_mem[col*NB + row];
    return 0;
  endfunction

  task automatic append_vec(input int k, input bit gaps);
    for (int b = 0; b < NB; b++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          wr_valid = 1'b0;
          tick();
          check("commit_idle_gap", commit, 0);
        end
      end
      wr_valid = 1'b1;
      wr_data  = W'(k*256 + b);
      tick();
      model_mem[cnt*NB + b] = k*256 + b;
      check("commit_pulse", commit, (b == NB-1));
    end
    wr_valid = 1'b0;
    cnt++;
    check("size_after_commit", size, cnt-1);
    check("empty_after_commit", empty, 0);
    check("full_after_commit", full, (cnt == NE));
  endtask

  task automatic read_pair(input int ca, input int ra, input int cb, input int rb);
    U_col = 5'(ca); U_row = 7'(ra); nvt_row = 5'(cb); nvt_col = 7'(rb);
    addr_valid_in = 1'b1;
    tick();
    addr_valid_in = 1'b0;
    check("read_valid", valid_out, 1);
    check("read_U", U_in, exp_word(ca, ra));
    check("read_nvt", nvt_in, exp_word(cb, rb));
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; wr_data = '0; wr_valid = 1'b0;
    U_col = '0; U_row = '0; nvt_row = '0; nvt_col = '0; addr_valid_in = 1'b0;
    #12;
    check("rst_U_in", U_in, 0);
    check("rst_nvt_in", nvt_in, 0);
    check("rst_commit", commit, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_full", full, 0);
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_empty", empty, 1);
      check("idle_size", size, 0);
      check("idle_wr_ready", wr_ready, 1);
      check("idle_valid_out", valid_out, 0);
    end

    // Vector 0 with continuous wr_valid, then read (0,50) on both ports.
    append_vec(0, 1'b0);
    read_pair(0, 50, 0, 50);
    check("read_0_50_value", U_in, 50);
    tick();
    check("valid_out_drops", valid_out, 0);

    append_vec(1, 1'b1);

    // Stream reads of column 1 while vector 2 is appended.
    vcount = 0;
    fork
      append_vec(2, 1'b1);
      begin
        for (int r = 0; r < NB; r++) begin
          U_col = 5'd1; U_row = 7'(r); nvt_row = 5'd1; nvt_col = 7'(NB-1-r);
          addr_valid_in = 1'b1;
          tick();
          if (valid_out) vcount++;
          check("stream_U", U_in, model_mem[NB + r]);
          check("stream_nvt", nvt_in, model_mem[NB + NB-1-r]);
        end
        addr_valid_in = 1'b0;
        tick();
        check("stream_valid_drop", valid_out, 0);
      end
    join
    check("stream_valid_cycles", vcount, NB);

`ifdef ENDMEMBER_STORE_RANGE_CHECK_EN
    check("size_is_2", size, 2);
    read_pair(5, 0, 1, 3);
    check("addr_err_set", addr_err, 1);
    read_pair(0, NB, 2, 7);
    repeat (3) begin
      tick();
      check("addr_err_sticky", addr_err, 1);
    end
`endif

    // Clear together with wr_valid at band 40 of vector 3.
    for (int b = 0; b < 40; b++) begin
      wr_valid = 1'b1; wr_data = W'(3*256 + b);
      tick();
      check("partial_no_commit", commit, 0);
    end
    wr_valid = 1'b1; wr_data = W'(3*256 + 40); clear = 1'b1;
    tick();
    clear = 1'b0; wr_valid = 1'b0;
    cnt = 0;
    check("clear_commit", commit, 0);
    check("clear_empty", empty, 1);
    check("clear_size", size, 0);
    check("clear_wr_ready", wr_ready, 1);
    check("clear_addr_err", addr_err, 0);
    tick();
    check("clear_commit_later", commit, 0);

    // Refill all 20 columns with random gaps.
    for (int k = 0; k < NE; k++) begin
      append_vec(k, 1'b1);
      if (k == 0) read_pair(0, 77, 0, 0);
    end
    check("full_set", full, 1);
    check("full_wr_ready", wr_ready, 0);
    check("full_size", size, NE-1);

    wr_valid = 1'b1; wr_data = 16'hBEEF;
    tick();
    wr_valid = 1'b0;
    check("extra_no_commit", commit, 0);
    check("extra_still_full", full, 1);
    read_pair(19, 102, 19, 102);
    check("read_19_102", U_in, 19*256 + 102);

    for (int i = 0; i < 16; i++) begin
      read_pair($urandom_range(0, NE-1), $urandom_range(0, NB-1),
                $urandom_range(0, NE-1), $urandom_range(0, NB-1));
    end

    // Leave FULL via clear, then reset in the middle of an append.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cnt = 0;
    check("clear_from_full_ready", wr_ready, 1);
    for (int b = 0; b < 10; b++) begin
      wr_valid = 1'b1; wr_data = W'(b);
      tick();
    end
    wr_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_empty", empty, 1);
    check("midrst_size", size, 0);
    check("midrst_wr_ready", wr_ready, 1);
    check("midrst_valid_out", valid_out, 0);
    tick();
    rst = 1'b0;
    append_vec(7, 1'b1);
    read_pair(0, 3, 0, 102);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/endmember_store.md
# endmember_store

Buffer that holds the endmember spectra selected so far and serves them to the incremental Gram/Cholesky inversion stage. Upstream selection logic streams each newly chosen spectrum in, one band per cycle. Once a spectrum is fully written it is committed and becomes the newest column. The inversion stage reads the stored columns (`U`) and the newest vector (`new_vectorT`) through two independent address ports with one-cycle latency, and takes `size` from this block.

## Interface
- `I_WIDTH`, 16: width of one spectral sample (unsigned integer).
- `SPECTRAL_BANDS`, 103: samples per endmember vector.
- `TOTAL_ENDMEMBERS`, 20: maximum number of stored vectors.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `clear`  in  1: synchronous; empties the store.
- `wr_data`  in  I_WIDTH: sample of the vector being appended, band order 0 upward.
- `wr_valid`  in  1: `wr_data` is valid.
- `wr_ready`  out  1: store accepts a sample this cycle.
- `commit`  out  1: one-cycle pulse when a vector completes.
- `U_col`  in  clog2(TOTAL_ENDMEMBERS): read column (endmember index), port A.
- `U_row`  in  clog2(SPECTRAL_BANDS): read row (band), port A.
- `new_vectorT_row`  in  clog2(TOTAL_ENDMEMBERS): read endmember index, port B.
- `new_vectorT_col`  in  clog2(SPECTRAL_BANDS): read band, port B.
- `addr_valid_in`  in  1: both read addresses are valid this cycle.
- `U_in`  out  I_WIDTH: port A read data.
- `new_vectorT_in`  out  I_WIDTH: port B read data.
- `valid_out`  out  1: read data is valid.
- `size`  out  clog2(TOTAL_ENDMEMBERS): index of the newest committed vector.
- `empty`  out  1: no vector committed.
- `full`  out  1: `TOTAL_ENDMEMBERS` vectors committed.
- `addr_err`  out  1: sticky out-of-range read flag (see Configuration).

## Operation
- Storage holds `TOTAL_ENDMEMBERS*SPECTRAL_BANDS` words at word address `col*SPECTRAL_BANDS + row`.
  - It has one write port and two read ports.
  - Contents are not reset and not cleared.
- Internal registers:
  - `count`, range 0..TOTAL_ENDMEMBERS.
  - `wr_row`, range 0..SPECTRAL_BANDS-1.
- Derived outputs:
  - `size = (count==0) ? 0 : count-1`.
  - `empty = (count==0)`.
  - `full = (count==TOTAL_ENDMEMBERS)`.
- FSM states: IDLE, LOAD, FULL.
  - IDLE, on an accepted sample: write it to (`count`, 0), set `wr_row`=1, go to LOAD.
  - LOAD, on an accepted sample: write it to (`count`, `wr_row`).
    - If `wr_row==SPECTRAL_BANDS-1`: set `wr_row`=0, increment `count`, pulse `commit`, then go to FULL if the new `count==TOTAL_ENDMEMBERS`, else to IDLE.
    - Otherwise increment `wr_row`.
  - FULL: `wr_ready`=0; samples are ignored. Only `clear` or `rst` leaves this state.
- `wr_ready = (state != FULL)`. A sample is accepted when `wr_valid & wr_ready`.
- `clear` has priority over a write in the same cycle.
  - It sets `count`=0, `wr_row`=0, state IDLE, `addr_err`=0.
  - A partial vector in progress is discarded.
- Writes go only to slot `count`, which is never a committed slot. Reads of committed slots may therefore overlap an in-progress append with no hazard.
- A read of column `count` during LOAD returns partially written data. The reader must not issue it.

## Timing
- Reset values:
  - `U_in`=0, `new_vectorT_in`=0.
  - `valid_out`=0, `commit`=0, `addr_err`=0.
  - `size`=0, `empty`=1, `full`=0.
  - `wr_ready`=1, state IDLE.
- Read latency is 1 cycle.
  - If `addr_valid_in` is sampled high at edge n, data for those addresses is registered at edge n and `valid_out` is high for the following cycle.
  - `valid_out` follows `addr_valid_in` delayed by one cycle. Back-to-back reads give one word per cycle.
- Write throughput is 1 sample/cycle. A full vector takes `SPECTRAL_BANDS` accepted cycles.
- `commit` and the updated `count`/`size`/`full` all take effect on the same edge that writes the last sample.
- A read issued in the cycle after `commit` may address the new column.
- `rst` mid-append: the state and counters return to reset values immediately. The partial vector is lost.

## Configuration
- `ENDMEMBER_STORE_RANGE_CHECK_EN` defined:
  - A read is out of range when, on either port, the column is greater than `size`, the column is read while `empty`, or the row is `>= SPECTRAL_BANDS`.
  - An out-of-range port returns 0 (with `valid_out` still asserted) and sets `addr_err` until `clear`/`rst`.
- Not defined:
  - No checking is done and `addr_err` is tied 0.
  - Out-of-range data is unspecified, but the block must not hang.

## Test plan
- Reset, then idle: `empty`=1, `size`=0, `wr_ready`=1, `valid_out`=0 for 10 cycles.
- Append vector k with samples `k*256+b` for b=0..102, with `wr_valid` continuous:
  - `commit` pulses on the 103rd accepted sample.
  - `size`=0 and `empty`=0 on the same edge.
  - Read (0,50) on both ports → 50 on both, one cycle later.
- Append 20 vectors with random `wr_valid` gaps:
  - `full`=1 and `wr_ready`=0 after the 20th commit.
  - A 21st sample is ignored.
  - Read (19,102) → 19*256+102.
- `clear` asserted together with `wr_valid` at band 40 of vector 3:
  - `count`=0, `empty`=1, `commit` does not pulse.
  - The next append lands in column 0.
- With the macro defined and `size`=2: read `U_col`=5 → `U_in`=0 and `addr_err`=1; it stays 1 until `clear`.
- Stream 103 back-to-back reads of column 1 while vector 2 is being appended:
  - Every returned word matches the stored value.
  - `valid_out` is high for exactly 103 cycles.
